// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared constants for the SPI target front end and its users:
//            SPI mode, byte width, idle return byte and decoder opcodes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

   // Mode 0: SCLK idles low, data sampled on the rising edge
   localparam logic       SPI_CPOL    = 1'b0;
   localparam logic       SPI_CPHA    = 1'b0;

   localparam int         SPI_BYTE_W  = 8;
   localparam int         SPI_CNT_W   = 3;

   localparam logic [7:0] SPI_IDLE_TX = 8'h00;

   // Opcodes understood by the command decoder
   localparam logic [7:0] OP_INFO_RD  = 8'h3a;
   localparam logic [7:0] OP_DATA_RD  = 8'h3b;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : Single-bit multi-flop synchroniser for an asynchronous input.
// Ports    : clk_i   - destination clock
//            rst_n_i - asynchronous active-low reset
//            d_i     - asynchronous input
//            q_o     - synchronised output (last flop of the chain)
// Params   : STAGES  - chain depth, must be at least 2
//            RST_VAL - value every flop takes during reset
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Oversampled SPI mode-0 target. Synchronises the SPI pins into
//            clk_i, deserialises MOSI into bytes (MSB first) with a one-cycle
//            strobe and DC flag, and serialises a return byte onto MISO.
// Ports    : clk_i, rst_n_i           - system clock, async active-low reset
//            spi_sclk_i, spi_cs_n_i,
//            spi_mosi_i, spi_dc_i     - asynchronous SPI pins
//            spi_miso_o               - registered serial return data
//            spi_byte_vld_o           - one-cycle strobe per received byte
//            spi_byte_data_o          - last received byte
//            spi_byte_dc_o            - DC level captured with that byte
//            tx_byte_i                - return byte from the read mux
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave
   import spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_TX     = SPI_IDLE_TX
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       spi_sclk_i,
   input  logic       spi_cs_n_i,
   input  logic       spi_mosi_i,
   input  logic       spi_dc_i,
   output logic       spi_miso_o,
   output logic       spi_byte_vld_o,
   output logic [7:0] spi_byte_data_o,
   output logic       spi_byte_dc_o,
   input  logic [7:0] tx_byte_i
);

   // ---------------------------------------------------------------- sync
   logic sclk_s, cs_n_s, mosi_s, dc_s;

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_sclk_i), .q_o(sclk_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_cs_n_i), .q_o(cs_n_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_mosi_i), .q_o(mosi_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(spi_dc_i), .q_o(dc_s));

   // ---------------------------------------------------------- edge detect
   logic sclk_prev_q, cs_n_prev_q;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   assign sclk_rise =  sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s &  sclk_prev_q;
   assign cs_fall   = ~cs_n_s &  cs_n_prev_q;
   assign cs_rise   =  cs_n_s & ~cs_n_prev_q;

   // ---------------------------------------------------------------- state
   logic [SPI_CNT_W-1:0]  cnt_q,  cnt_d;
   logic [SPI_BYTE_W-1:0] rx_q,   rx_d;
   logic [SPI_BYTE_W-1:0] tx_q,   tx_d;
   logic [SPI_BYTE_W-1:0] data_q, data_d;
   logic                  load_q, load_d;
   logic                  vld_q,  vld_d;
   logic                  dc_q,   dc_d;
   logic                  miso_q, miso_d;

   always_comb begin
      cnt_d  = cnt_q;
      rx_d   = rx_q;
      tx_d   = tx_q;
      data_d = data_q;
      load_d = load_q;
      dc_d   = dc_q;
      vld_d  = 1'b0;

      // CS is evaluated first, so an SCLK edge coinciding with CS rising is
      // dropped together with the partial byte.
      if (cs_rise) begin
         cnt_d  = '0;
         load_d = 1'b0;
      end else if (cs_fall) begin
         cnt_d  = '0;
         rx_d   = '0;
         tx_d   = IDLE_TX;
         load_d = 1'b0;
      end else if (!cs_n_s) begin
         if (sclk_rise) begin
            rx_d  = {rx_q[6:0], mosi_s};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               vld_d  = 1'b1;
               data_d = rx_d;
               dc_d   = dc_s;
               load_d = 1'b1;
            end
         end
         // The first falling edge after a completed byte presents the next
         // return byte; all others advance the shifter.
         if (sclk_fall) begin
            if (load_q) begin
               tx_d   = tx_byte_i;
               load_d = 1'b0;
            end else begin
               tx_d   = {tx_q[6:0], 1'b0};
            end
         end
      end

      // Driven from the next-state shifter so MISO tracks the shift in the
      // same cycle it is registered.
      miso_d = ~cs_n_s & tx_d[7];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sclk_prev_q <= 1'b0;
         cs_n_prev_q <= 1'b1;
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= IDLE_TX;
         data_q      <= '0;
         load_q      <= 1'b0;
         vld_q       <= 1'b0;
         dc_q        <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_s;
         cs_n_prev_q <= cs_n_s;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         data_q      <= data_d;
         load_q      <= load_d;
         vld_q       <= vld_d;
         dc_q        <= dc_d;
         miso_q      <= miso_d;
      end
   end

   assign spi_miso_o      = miso_q;
   assign spi_byte_vld_o  = vld_q;
   assign spi_byte_data_o = data_q;
   assign spi_byte_dc_o   = dc_q;

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave. A master model shifts bytes
//            at SCLK = clk/8; a read-mux model supplies the return byte
//            selected by the number of strobes seen so far.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;
   import spi_pkg::*;

   localparam logic [7:0] IDLE = SPI_IDLE_TX;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sclk, cs_n, mosi, dc;
   logic       miso, vld, bdc;
   logic [7:0] bdata, tx_byte;

   int checks   = 0;
   int failures = 0;

   // Written only by the strobe monitor
   int         strobe_cnt = 0;
   int         width_errs = 0;
   logic       prev_vld   = 1'b0;
   logic [8:0] rx_q[$];

   logic [7:0] resp_tab [0:255];
   logic [7:0] mo_tab   [0:15];
   logic       dc_tab   [0:15];

   always #5 clk = ~clk;

   // Read mux model: the return byte for byte N+1 is indexed by strobe count
   assign tx_byte = resp_tab[strobe_cnt[7:0]];

   spi_slave #(.SYNC_STAGES(2), .IDLE_TX(IDLE)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .spi_sclk_i     (sclk),
      .spi_cs_n_i     (cs_n),
      .spi_mosi_i     (mosi),
      .spi_dc_i       (dc),
      .spi_miso_o     (miso),
      .spi_byte_vld_o (vld),
      .spi_byte_data_o(bdata),
      .spi_byte_dc_o  (bdc),
      .tx_byte_i      (tx_byte)
   );

   always @(negedge clk) begin
      if (vld === 1'b1) begin
         if (prev_vld) width_errs++;
         rx_q.push_back({bdc, bdata});
         strobe_cnt++;
      end
      prev_vld = (vld === 1'b1);
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: run did not complete (actual=timeout required=finish)");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ master
   task automatic xfer(input logic [7:0] mo, input logic d, input int nbits,
                       output logic [7:0] mi);
      mi = '0;
      dc = d;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = mo[i];
         repeat (4) @(negedge clk);
         mi[i] = miso;
         sclk  = 1'b1;
         repeat (4) @(negedge clk);
         sclk  = 1'b0;
      end
   endtask

   // One CS-low session of n full bytes from mo_tab/dc_tab, checking MISO
   // per byte, the strobe count and the received bytes in order.
   task automatic run_session(input string name, input int n);
      int         base;
      logic [7:0] mi, exp_mi;
      logic [8:0] got;
      base = strobe_cnt;
      rx_q.delete();
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 0; k < n; k++) begin
         xfer(mo_tab[k], dc_tab[k], 8, mi);
         exp_mi = (k == 0) ? IDLE : resp_tab[(base + k) % 256];
         checks++;
         if (mi !== exp_mi) begin
            failures++;
            $display("FAIL %s miso byte%0d: got=%h exp=%h", name, k, mi, exp_mi);
         end
      end
      repeat (8) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (strobe_cnt - base != n) begin
         failures++;
         $display("FAIL %s strobe_count: got=%0d exp=%0d", name, strobe_cnt - base, n);
      end
      for (int k = 0; k < n; k++) begin
         got = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1ff;
         checks++;
         if (got !== {dc_tab[k], mo_tab[k]}) begin
            failures++;
            $display("FAIL %s rx byte%0d: got dc=%b data=%h exp dc=%b data=%h",
                     name, k, got[8], got[7:0], dc_tab[k], mo_tab[k]);
         end
      end
   endtask

   // ------------------------------------------------------------- tests
   task automatic check_outputs_reset(input string name);
      checks++;
      if (miso !== 1'b0) begin failures++; $display("FAIL %s miso: got=%b exp=0", name, miso); end
      checks++;
      if (vld !== 1'b0) begin failures++; $display("FAIL %s vld: got=%b exp=0", name, vld); end
      checks++;
      if (bdata !== 8'h00) begin failures++; $display("FAIL %s data: got=%h exp=00", name, bdata); end
      checks++;
      if (bdc !== 1'b0) begin failures++; $display("FAIL %s dc: got=%b exp=0", name, bdc); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; dc = 1'b0;
      for (int i = 0; i < 256; i++) resp_tab[i] = 8'h00;
      #2;
      check_outputs_reset("reset_initial");
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_command();
      mo_tab[0] = OP_DATA_RD; dc_tab[0] = 1'b0;
      run_session("command", 1);
   endtask

   task automatic test_read_return();
      resp_tab[(strobe_cnt + 1) % 256] = 8'hA5;
      mo_tab[0] = OP_DATA_RD; dc_tab[0] = 1'b0;
      mo_tab[1] = 8'hFF;      dc_tab[1] = 1'b1;
      run_session("read_return", 2);
   endtask

   task automatic test_abort();
      int         base;
      logic [7:0] mi;
      base = strobe_cnt;
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      xfer(OP_INFO_RD, 1'b0, 5, mi);
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (strobe_cnt != base) begin
         failures++;
         $display("FAIL abort no_strobe: got=%0d exp=0", strobe_cnt - base);
      end
      mo_tab[0] = OP_INFO_RD; dc_tab[0] = 1'b0;
      run_session("abort_recover", 1);
   endtask

   task automatic test_back_to_back();
      int base;
      base = strobe_cnt;
      for (int k = 0; k < 4; k++) begin
         mo_tab[k] = 8'(k + 1);
         dc_tab[k] = 1'b1;
         resp_tab[(base + k + 1) % 256] = 8'(8'h11 * (k + 1));
      end
      run_session("back_to_back", 4);
   endtask

   task automatic test_noise();
      int base;
      base = strobe_cnt;
      cs_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         mosi = 1'($urandom_range(0, 1));
         sclk = ~sclk;
         repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (strobe_cnt != base) begin
         failures++;
         $display("FAIL noise no_strobe: got=%0d exp=0", strobe_cnt - base);
      end
      mo_tab[0] = 8'h55; dc_tab[0] = 1'b1;
      run_session("noise_recover", 1);
   endtask

   task automatic test_random();
      int base;
      base = strobe_cnt;
      for (int k = 0; k < 6; k++) begin
         mo_tab[k] = 8'($urandom_range(0, 255));
         dc_tab[k] = 1'($urandom_range(0, 1));
         resp_tab[(base + k + 1) % 256] = 8'($urandom_range(0, 255));
      end
      run_session("random", 6);
   endtask

   task automatic test_reset_mid_transfer();
      logic [7:0] mi;
      resp_tab[(strobe_cnt + 1) % 256] = 8'hFF;
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      xfer(8'hC3, 1'b1, 8, mi);
      xfer(8'h00, 1'b1, 3, mi);
      checks++;
      if (bdata !== 8'hC3 || bdc !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset byte: got dc=%b data=%h exp dc=1 data=c3", bdc, bdata);
      end
      checks++;
      if (miso !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset miso: got=%b exp=1", miso);
      end
      rst_n = 1'b0;
      #1;
      check_outputs_reset("reset_mid");
      cs_n = 1'b1; sclk = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      mo_tab[0] = OP_INFO_RD; dc_tab[0] = 1'b0;
      run_session("reset_recover", 1);
   endtask

   task automatic test_strobe_width();
      checks++;
      if (width_errs !== 0) begin
         failures++;
         $display("FAIL strobe_width: got=%0d multi-cycle strobes exp=0", width_errs);
      end
   endtask

   initial begin
      test_reset();
      test_command();
      test_read_return();
      test_abort();
      test_back_to_back();
      test_noise();
      test_random();
      test_reset_mid_transfer();
      test_strobe_width();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_spi_slave
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
Front-end SPI target for the register-read path. It brings SCLK, CS_N, MOSI and DC into the clk_i domain. It deserialises MOSI into bytes, each with a one-cycle valid strobe and its DC flag, for the command decoder. It serialises a return byte onto MISO, which the register read mux supplies. SPI mode 0 (CPOL=0, CPHA=0), MSB first, oversampled; clk_i must be at least 4x SCLK.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2)
IDLE_TX, 8'h00, byte returned on MISO when no read data is loaded

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
spi_sclk_i  input  1  SPI clock, asynchronous
spi_cs_n_i  input  1  SPI chip select, active low, asynchronous
spi_mosi_i  input  1  SPI data in, asynchronous
spi_dc_i  input  1  data/command pin, asynchronous; 0 = command, 1 = data
spi_miso_o  output  1  SPI data out
spi_byte_vld_o  output  1  one-cycle strobe: new received byte
spi_byte_data_o  output  8  last received byte
spi_byte_dc_o  output  1  DC level captured with that byte
tx_byte_i  input  8  return byte from the register read mux

Behaviour:
- Reset values (async assert, sync release inside clk_i): all synchroniser flops 0 except cs_n chain = 1. spi_miso_o=0, spi_byte_vld_o=0, spi_byte_data_o=8'h00, spi_byte_dc_o=0. Bit counter=0, rx shift=0, tx shift=IDLE_TX.
- Synchronisers: sclk, cs_n, mosi and dc each pass through SYNC_STAGES flops.
- Edge detect: rise = sync sclk 1 and previous 0; fall = sync sclk 0 and previous 1.
- Edges count only while sync cs_n = 0.
- Input latency: external pin to edge detect = SYNC_STAGES+1 clk_i cycles.
- CS falling (sync): bit counter <= 0, rx shift cleared, tx shift <= IDLE_TX.
- Rise edge with CS active:
  - rx shift <= {rx[6:0], mosi_sync}; bit counter += 1 (3-bit, wraps 7 -> 0).
  - On the rise where the counter is 7, the next cycle drives spi_byte_vld_o=1 for exactly one cycle. spi_byte_data_o gets the full byte, spi_byte_dc_o gets dc_sync at that rise.
  - Flag load_pending <= 1.
- Data outputs hold until the next completed byte. Consecutive bytes with no gap produce separate strobes at least 8 SCLK periods apart.
- Fall edge with CS active:
  - If load_pending: tx shift <= tx_byte_i, load_pending <= 0. The read mux therefore has at least 2 clk_i cycles after the strobe to present data.
  - Otherwise: tx shift <= {tx[6:0], 1'b0}.
- spi_miso_o = tx shift[7] while sync cs_n = 0; otherwise 0. Registered; no tristate.
- First byte after CS fall returns IDLE_TX. Byte N+1 on MISO carries tx_byte_i as sampled at the fall after byte N completed.
- CS rising (sync) mid-byte: partial byte discarded, no strobe; counter <= 0, load_pending <= 0.
- CS rise in the same cycle as a sync SCLK rise: edge ignored (CS evaluated first).
- SCLK edges while CS is high: ignored, no state change.
- Reset mid-transfer: all state returns to reset values immediately. The next valid byte requires a fresh CS falling edge.
- Bit counter width is 3 bits; rx/tx shift registers are 8 bits; no other arithmetic.

Decomposition:
- Package spi_pkg: mode constants (CPOL/CPHA = 0), SPI_BYTE_W = 8, IDLE_TX default, and the command opcodes already used by the decoder (INFO_RD 8'h3a, DATA_RD 8'h3b) so bench and RTL share them.
- One natural sub-module, sync_ff: a parameterised SYNC_STAGES-deep synchroniser with reset value parameter. Instantiate it four times.
- Edge detect, counter and shift registers stay in spi_slave.

Test Plan:
- Reset: rst_n_i=0 mid-run -> miso=0, vld=0, data=8'h00, dc=0 immediately.
- Command byte: CS low, DC=0, shift 8'h3b at SCLK = clk/8 -> one vld pulse, data=8'h3b, dc=0, MISO during that byte = 8'h00.
- Read return: after 8'h3b, bench drives tx_byte_i=8'hA5 within 2 cycles of vld. Next byte DC=1, MOSI 8'hFF -> MISO shifts 1010_0101 MSB first; vld with data=8'hFF, dc=1.
- Abort: CS high after 5 bits of 8'h3a -> no vld. Next CS-low byte 8'h3a -> single vld, data=8'h3a.
- Back-to-back: 4 bytes 8'h01..8'h04 with no SCLK gap -> exactly 4 strobes, data in order. MISO shows IDLE_TX, then the tx_byte_i values loaded after each strobe.
- Noise immunity: SCLK toggling while CS high (10 edges) -> no vld, counter unchanged. The following CS-low byte 8'h55 is received correctly.
